stoch_vec_decoder: RTL

- Converts VEC_LEN pairs of sign-split stochastic bitstreams (x_p positive part, x_m negative part, one bit per element per cycle) into signed fixed-point counts.
- Integrates each pair over a fixed window of 2^WIN_LOG2 enabled cycles and emits one vector per window with a valid strobe.
- Sits downstream of the stochastic vector arithmetic (cross product, saturating add/sub) to read results back into the deterministic domain.

---
 rtl/stoch_vec_decoder_pkg.sv | 29 ++
 rtl/stoch_vec_decoder_sm_acc.sv | 45 ++++
 rtl/stoch_vec_decoder.sv | 98 +++++++++
 3 files changed

// File: rtl/stoch_vec_decoder_pkg.sv
// Shared definitions for the stochastic-to-binary readout path: window defaults,
// accumulator sizing and the per-cycle step decode of a sign-split bit pair.
package stoch_vec_decoder_pkg;

    localparam int DEFAULT_WIN_LOG2 = 8;
    localparam int DEFAULT_VEC_LEN  = 3;

    typedef enum logic [1:0] {
        STEP_HOLD = 2'b00,
        STEP_UP   = 2'b01,
        STEP_DOWN = 2'b10
    } step_e;

    // Two extra bits: one for the sign, one so that +2^WIN_LOG2 itself is representable.
    function automatic int acc_width(input int win_log2);
        return win_log2 + 2;
    endfunction

    function automatic step_e decode_step(input logic xp, input logic xm);
        step_e s;
        case ({xp, xm})
            2'b10:   s = STEP_UP;
            2'b01:   s = STEP_DOWN;
            default: s = STEP_HOLD;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/stoch_vec_decoder_sm_acc.sv
// Signed integrator for one sign-split stochastic stream pair.
// clr has priority over en so that an abort or window close always lands on zero.
module stoch_sm_acc
    import stoch_vec_decoder_pkg::*;
#(
    parameter int ACC_W = acc_width(DEFAULT_WIN_LOG2)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    en,
    input  logic                    clr,
    input  logic                    x_p,
    input  logic                    x_m,
    output logic signed [ACC_W-1:0] sum
);

    localparam logic signed [ACC_W-1:0] ONE = ACC_W'(1);

    logic signed [ACC_W-1:0] sum_q;
    logic signed [ACC_W-1:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr) begin
            sum_d = '0;
        end else if (en) begin
            case (decode_step(x_p, x_m))
                STEP_UP:   sum_d = sum_q + ONE;
                STEP_DOWN: sum_d = sum_q - ONE;
                default:   sum_d = sum_q;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/stoch_vec_decoder.sv
// Windowed readout of VEC_LEN sign-split stochastic streams into signed counts,
// one result vector per 2^WIN_LOG2 enabled cycles with a one-cycle valid pulse.
module stoch_vec_decoder
    import stoch_vec_decoder_pkg::*;
#(
    parameter  int VEC_LEN  = DEFAULT_VEC_LEN,
    parameter  int WIN_LOG2 = DEFAULT_WIN_LOG2,
    localparam int ACC_W    = acc_width(WIN_LOG2)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     en,
    input  logic                     restart,
    input  logic [VEC_LEN-1:0]       x_p,
    input  logic [VEC_LEN-1:0]       x_m,
    output logic [VEC_LEN*ACC_W-1:0] y,
    output logic                     y_valid,
    output logic [WIN_LOG2-1:0]      win_cnt
);

    localparam logic [WIN_LOG2-1:0]     CNT_LAST = '1;
    localparam logic signed [ACC_W-1:0] ONE      = ACC_W'(1);

    logic [WIN_LOG2-1:0]      win_cnt_q;
    logic [WIN_LOG2-1:0]      win_cnt_d;
    logic [VEC_LEN*ACC_W-1:0] y_q;
    logic [VEC_LEN*ACC_W-1:0] y_d;
    logic                     y_valid_q;
    logic                     terminal;
    logic                     clr;
    logic [VEC_LEN*ACC_W-1:0] closing_all;

    // restart beats the terminal cycle: an aborted window never produces a result.
    assign terminal = en && !restart && (win_cnt_q == CNT_LAST);
    assign clr      = restart || terminal;

    for (genvar i = 0; i < VEC_LEN; i++) begin : g_elem
        logic signed [ACC_W-1:0] sum;
        logic signed [ACC_W-1:0] closing;

        stoch_sm_acc #(
            .ACC_W (ACC_W)
        ) u_acc (
            .CLK   (CLK),
            .RST   (RST),
            .en    (en),
            .clr   (clr),
            .x_p   (x_p[i]),
            .x_m   (x_m[i]),
            .sum   (sum)
        );

        // The closing value must include the bits of the terminal cycle itself.
        always_comb begin
            closing = sum;
            case (decode_step(x_p[i], x_m[i]))
                STEP_UP:   closing = sum + ONE;
                STEP_DOWN: closing = sum - ONE;
                default:   closing = sum;
            endcase
        end

        assign closing_all[i*ACC_W +: ACC_W] = closing;
    end

    always_comb begin
        win_cnt_d = win_cnt_q;
        if (restart) begin
            win_cnt_d = '0;
        end else if (en) begin
            win_cnt_d = win_cnt_q + 1'b1;
        end
    end

    always_comb begin
        y_d = y_q;
        if (terminal) begin
            y_d = closing_all;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            win_cnt_q <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            win_cnt_q <= win_cnt_d;
            y_q       <= y_d;
            y_valid_q <= terminal;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign win_cnt = win_cnt_q;

endmodule
